turn_request_ctrl: RTL
======================

# turn_request_ctrl

Upstream control stage for the tail-light sequencers: debounces the raw left, right and hazard switch inputs and decides the active signalling mode. It then drives per-side enables, a one-cycle restart pulse and a shared step tick, so the left and right 3-lamp sequencers advance together at a fixed rate. Each sequencer advances one state per `step_tick` while enabled and returns to its first state on `restart`.

## Interface
- `DEBOUNCE_CYCLES`, default 4: consecutive samples a raw input must differ from its debounced value before that value flips; ≥2.
- `TICK_DIV`, default 8: clock cycles per `step_tick` period; ≥2.
- `clk` input 1: single clock, all logic on rising edge.
- `reset` input 1: synchronous, active-high.
- `left_sw` input 1: raw left-turn switch, synchronous to `clk`.
- `right_sw` input 1: raw right-turn switch.
- `hazard_sw` input 1: raw hazard switch.
- `mode` output 2: current mode (`mode_t`), registered.
- `left_en` output 1: left sequencer enable, registered.
- `right_en` output 1: right sequencer enable, registered.
- `restart` output 1: one-cycle pulse on every mode change.
- `step_tick` output 1: one-cycle step pulse, never asserted in IDLE.

## Operation
- Reset: all debounced values 0, debounce counters 0, `mode`=IDLE, `left_en`=`right_en`=`restart`=`step_tick`=0, prescaler 0.
- Debounce, per input: if raw ≠ debounced, counter increments. If raw = debounced, counter clears. When the counter is at DEBOUNCE_CYCLES-1 and raw still differs, the debounced value takes raw and the counter clears. A glitch shorter than DEBOUNCE_CYCLES cycles has no effect.
- Mode decode from the debounced values (d_l, d_r, d_h), in priority order:
  - d_h=1 → HAZARD
  - d_l=1 and d_r=1 → HAZARD
  - d_l only → LEFT
  - d_r only → RIGHT
  - none → IDLE
- `mode` registers the decoded value each cycle.
- `left_en` = (mode ∈ {LEFT, HAZARD}); `right_en` = (mode ∈ {RIGHT, HAZARD}).
- Mode change, any transition including to IDLE: `restart`=1 for exactly the first cycle the new `mode` is visible, and the prescaler clears to 0 in that same cycle.
- Prescaler: 0..TICK_DIV-1, wrapping. Held at 0 while mode=IDLE. `step_tick`=1 in the cycle the count equals TICK_DIV-1 and mode≠IDLE.
- Simultaneous events:
  - A mode change in the cycle a tick would fire suppresses that tick; the restart takes precedence.
  - Several debounced inputs changing in one cycle yield a single mode change and one `restart`.
- Reset mid-operation: all state returns to reset values on the next edge. `restart` is not pulsed on the reset-to-IDLE transition.

## Timing
- Raw input stable at its new level from edge k: the debounced value flips at edge k+DEBOUNCE_CYCLES-1 and `mode`/enables/`restart` update at edge k+DEBOUNCE_CYCLES. Total latency is DEBOUNCE_CYCLES+1 cycles, counting from the first sampling edge.
- First `step_tick` after `restart` occurs TICK_DIV-1 cycles after the `restart` cycle. Subsequent ticks follow every TICK_DIV cycles.
- Every output is a flop output; no combinational path from any input to any output.

## Structure
- Package `tail_light_pkg`:
  - `typedef enum logic [1:0] {IDLE, LEFT, RIGHT, HAZARD} mode_t`.
  - Default values for DEBOUNCE_CYCLES and TICK_DIV.
  - Shared by the sequencers.
- Sub-module `sw_debounce` (one input, parameter DEBOUNCE_CYCLES), instantiated three times.
- The top holds mode decode, the mode register, enables, restart and the prescaler.
- Counter widths: $clog2 of each parameter.

## Test plan
- Reset then idle: hold `reset` 2 cycles, all switches 0 for 50 cycles → `mode`=IDLE, all outputs 0 throughout, no `step_tick`.
- Left request: `left_sw`=1 from edge 10 (defaults) → `mode`=LEFT, `left_en`=1, `restart`=1 at edge 14. First `step_tick` 7 cycles later, then every 8 cycles; `right_en` stays 0.
- Glitch rejection: `right_sw` high for 3 cycles then low → no change to `mode` or any output.
- Priority and change: LEFT active, then `hazard_sw`=1 → after 5 cycles `mode`=HAZARD, both enables 1, one `restart`, prescaler realigned. Release hazard → back to LEFT with another `restart`.
- Both turns plus tick collision: `left_sw` and `right_sw` debounced in the same cycle → single transition to HAZARD. A mode change aligned with prescaler count 7 → no `step_tick` in that cycle.
- Mid-operation reset: assert `reset` one cycle during RIGHT → next cycle all outputs 0, `mode`=IDLE, no `restart`. `right_sw` still high → RIGHT again after DEBOUNCE_CYCLES+1 cycles.

Source files
------------

// File: rtl/tail_light_pkg.sv
// Shared types and defaults for the tail-light control path and its sequencers.
package tail_light_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LEFT   = 2'd1,
    RIGHT  = 2'd2,
    HAZARD = 2'd3
  } mode_t;

  localparam int DEFAULT_DEBOUNCE_CYCLES = 4;
  localparam int DEFAULT_TICK_DIV        = 8;

  // Priority decode of the debounced switches: hazard, then both turns, then single turn.
  function automatic mode_t decode_mode(input logic d_l, input logic d_r, input logic d_h);
    mode_t m;
    if (d_h)             m = HAZARD;
    else if (d_l && d_r) m = HAZARD;
    else if (d_l)        m = LEFT;
    else if (d_r)        m = RIGHT;
    else                 m = IDLE;
    return m;
  endfunction

endpackage

// File: rtl/sw_debounce.sv
// Single-input debouncer: the output follows the raw input only after it has
// differed from the current debounced value for DEBOUNCE_CYCLES consecutive samples.
module sw_debounce
  import tail_light_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_i,
  output logic deb_o
);

  localparam int             CW      = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]  CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          deb_q, deb_d;

  // Count consecutive disagreeing samples; flip and clear on the last one.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
    cnt_d = '0;
    deb_d = deb_q;
    if (raw_i != deb_q) begin
      if (cnt_q == CNT_MAX) begin
        deb_d = raw_i;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // Debounce state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: flops are written with non-blocking assignments so every register samples pre-edge values.
      cnt_q <= '0;
      deb_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      deb_q <= deb_d;
    end
  end

  assign deb_o = deb_q;

endmodule

// File: rtl/turn_request_ctrl.sv
// Turn-request control stage: debounces the three switches, decodes the
// signalling mode and drives enables, a restart pulse and a shared step tick.
module turn_request_ctrl
  import tail_light_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int TICK_DIV        = DEFAULT_TICK_DIV
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       left_sw,
  input  logic       right_sw,
  input  logic       hazard_sw,
  output logic [1:0] mode,
  output logic       left_en,
  output logic       right_en,
  output logic       restart,
  output logic       step_tick
);

  localparam int            PW        = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  logic d_l, d_r, d_h;

  sw_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_left (
    .clk   (clk),
    .reset (reset),
    .raw_i (left_sw),
    .deb_o (d_l)
  );

  sw_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_right (
    .clk   (clk),
    .reset (reset),
    .raw_i (right_sw),
    .deb_o (d_r)
  );

  sw_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_hazard (
    .clk   (clk),
    .reset (reset),
    .raw_i (hazard_sw),
    .deb_o (d_h)
  );

  mode_t         mode_q, mode_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          left_en_q, right_en_q, restart_q, step_tick_q;
  logic          mode_change;
  logic          tick_d;

  // Next mode, prescaler and tick; a mode change realigns the prescaler and
  // therefore also suppresses any tick that would have landed on that cycle.
  always_comb begin
    mode_d      = decode_mode(d_l, d_r, d_h);
    mode_change = (mode_d != mode_q);
    presc_d     = '0;
    if (!mode_change && (mode_d != IDLE) && (presc_q != PRESC_MAX)) begin
      presc_d = presc_q + PW'(1);
    end
    tick_d = (mode_d != IDLE) && (presc_d == PRESC_MAX);
  end

  // Mode register with registered enables, restart pulse and step tick.
  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q      <= IDLE;
      presc_q     <= '0;
      left_en_q   <= 1'b0;
      right_en_q  <= 1'b0;
      restart_q   <= 1'b0;
      step_tick_q <= 1'b0;
    end else begin
      mode_q      <= mode_d;
      presc_q     <= presc_d;
      left_en_q   <= (mode_d == LEFT)  || (mode_d == HAZARD);
      right_en_q  <= (mode_d == RIGHT) || (mode_d == HAZARD);
      restart_q   <= mode_change;
      step_tick_q <= tick_d;
    end
  end

  assign mode      = mode_q;
  assign left_en   = left_en_q;
  assign right_en  = right_en_q;
  assign restart   = restart_q;
  assign step_tick = step_tick_q;

endmodule
